// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Purpose:
//   Decodes byte-oriented commands arriving from a UART receiver and turns
//   them into register-file accesses. A write is three bytes
//   (WR_CMD, address, data). A read is two bytes (RD_CMD, address); the read
//   data returned by the register file is handed to the UART transmitter.
//   Only one command is in flight at a time. Bytes that arrive while a read
//   response is pending, bytes flagged with an RX error, and unknown opcodes
//   are dropped and reported with a one-cycle CMD_ERR pulse.
//
// Ports:
//   CLK           in   clock, all logic on the rising edge
//   RST           in   synchronous active-high reset
//   RX_P_DATA     in   [7:0] received byte, qualified by RX_D_VLD
//   RX_D_VLD      in   one-cycle strobe: new RX byte
//   RX_ERR        in   parity/framing error for the current RX byte
//   TX_BUSY       in   UART transmitter busy
//   TX_P_DATA     out  [7:0] byte to transmit
//   TX_D_VLD      out  transmit request, held until TX_BUSY rises
//   WrEn          out  register-file write strobe
//   RdEn          out  register-file read strobe
//   Address       out  [ADDR_WIDTH-1:0] register-file address
//   WrData        out  [7:0] register-file write data
//   RdData        in   [7:0] register-file read data
//   RdData_Valid  in   one-cycle strobe: RdData valid
//   CMD_ERR       out  one-cycle pulse per dropped/invalid byte
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an opcode byte
// WR_ADDR | write opcode seen, waiting for the address byte
// WR_DATA | write address latched, waiting for the data byte
// RD_ADDR | read opcode seen, waiting for the address byte
// RD_WAIT | read strobe issued, waiting for RdData_Valid
// TX_REQ  | response byte offered, waiting for a fresh TX_BUSY rise
// TX_WAIT | transmitter accepted the byte, waiting for TX_BUSY to fall
// ----------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int         ADDR_WIDTH = 4,
    parameter logic [7:0] WR_CMD     = 8'hAA,
    parameter logic [7:0] RD_CMD     = 8'hBB
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_ERR,
    input  logic                  TX_BUSY,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [7:0]            WrData,
    input  logic [7:0]            RdData,
    input  logic                  RdData_Valid,
    output logic                  CMD_ERR
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_TX_REQ  = 3'd5;
    localparam logic [2:0] S_TX_WAIT = 3'd6;

    logic [2:0]            r_state;
    logic [7:0]            r_tx_data;
    logic                  r_tx_vld;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wr_data;
    logic                  r_cmd_err;
    logic                  r_busy_prev;

    logic                  w_rx_good;
    logic                  w_rx_bad;
    logic                  w_busy_rise;

    assign w_rx_good   = RX_D_VLD & ~RX_ERR;
    assign w_rx_bad    = RX_D_VLD &  RX_ERR;
    // A rise is only counted when the previous sample was low, so a frame
    // still in progress when TX_REQ is entered cannot be mistaken for
    // acceptance of the new byte.
    assign w_busy_rise = TX_BUSY & ~r_busy_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_tx_data   <= 8'h00;
            r_tx_vld    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= 8'h00;
            r_cmd_err   <= 1'b0;
            r_busy_prev <= 1'b0;
        end else begin
            r_busy_prev <= TX_BUSY;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_cmd_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_bad) begin
                        r_cmd_err <= 1'b1;
                    end else if (w_rx_good) begin
                        if (RX_P_DATA == WR_CMD) begin
                            r_state <= S_WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            r_state <= S_RD_ADDR;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end

                S_WR_ADDR: begin
                    if (w_rx_bad) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_rx_good) begin
                        r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (w_rx_bad) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_rx_good) begin
                        r_wr_data <= RX_P_DATA;
                        r_wr_en   <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (w_rx_bad) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_rx_good) begin
                        r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_rd_en <= 1'b1;
                        r_state <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    // Any RX byte here is dropped, even in the same cycle as
                    // the read data; the read response still proceeds.
                    if (RX_D_VLD) begin
                        r_cmd_err <= 1'b1;
                    end
                    if (RdData_Valid) begin
                        r_tx_data <= RdData;
                        r_tx_vld  <= 1'b1;
                        r_state   <= S_TX_REQ;
                    end
                end

                S_TX_REQ: begin
                    if (RX_D_VLD) begin
                        r_cmd_err <= 1'b1;
                    end
                    if (w_busy_rise) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= S_TX_WAIT;
                    end
                end

                S_TX_WAIT: begin
                    if (RX_D_VLD) begin
                        r_cmd_err <= 1'b1;
                    end
                    if (!TX_BUSY) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_tx_vld <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign CMD_ERR   = r_cmd_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Drives RX bytes, plays the register file and the UART transmitter, and
// predicts every register-file access, transmitted byte and error pulse from
// the command rules. Predictions go into queues; an independent monitor pops
// them whenever the controller presents an output.
// ----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = 8'h00;
    logic       RX_D_VLD = 1'b0;
    logic       RX_ERR = 1'b0;
    logic       TX_BUSY = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData = 8'h00;
    logic       RdData_Valid = 1'b0;
    logic       CMD_ERR;

    uart_cmd_ctrl #(.ADDR_WIDTH(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  rd_table [16];
    logic [7:0]  cbuf [$];
    logic [11:0] exp_wr [$];   // {addr, data}
    logic [3:0]  exp_rd [$];
    logic [7:0]  exp_tx [$];
    int          exp_err = 0;
    bit          inflight = 0;

    task automatic model_byte(input logic [7:0] b, input bit e,
                              output bit o_err, output bit o_wr, output bit o_rd);
        o_err = 0; o_wr = 0; o_rd = 0;
        if (inflight || e) begin
            o_err = 1;
            if (!inflight) cbuf.delete();
        end else if (cbuf.size() == 0) begin
            if (b == 8'hAA || b == 8'hBB) cbuf.push_back(b);
            else o_err = 1;
        end else begin
            cbuf.push_back(b);
            if (cbuf[0] == 8'hBB) begin
                o_rd = 1;
                exp_rd.push_back(b[3:0]);
                exp_tx.push_back(rd_table[b[3:0]]);
                inflight = 1;
                cbuf.delete();
            end else if (cbuf.size() == 3) begin
                o_wr = 1;
                exp_wr.push_back({cbuf[1][3:0], cbuf[2]});
                cbuf.delete();
            end
        end
        if (o_err) exp_err++;
    endtask

    // ---------------- monitor ----------------
    logic       mon_prev_vld = 1'b0;
    logic [7:0] mon_held = 8'h00;

    initial begin
        logic [11:0] w;
        logic [3:0]  a;
        logic [7:0]  t;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (WrEn && RdEn) chk("wr_rd_exclusive", 1, 0);
                if (WrEn) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", int'(Address), int'(w[11:8]));
                        chk("wr_data", int'(WrData), int'(w[7:0]));
                    end
                end
                if (RdEn) begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                    else begin
                        a = exp_rd.pop_front();
                        chk("rd_addr", int'(Address), int'(a));
                    end
                end
                if (TX_D_VLD && !mon_prev_vld) begin
                    if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                    else begin
                        t = exp_tx.pop_front();
                        chk("tx_data", int'(TX_P_DATA), int'(t));
                    end
                    mon_held = TX_P_DATA;
                end else if (TX_D_VLD) begin
                    chk("tx_data_stable", int'(TX_P_DATA), int'(mon_held));
                end
                if (CMD_ERR) begin
                    if (exp_err == 0) chk("cmd_err_unexpected", 1, 0);
                    else exp_err--;
                end
            end
            mon_prev_vld = TX_D_VLD;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit e);
        bit xe, xw, xr;
        @(negedge CLK);
        RX_P_DATA = b; RX_ERR = e; RX_D_VLD = 1'b1;
        model_byte(b, e, xe, xw, xr);
        @(negedge CLK);
        RX_D_VLD = 1'b0; RX_ERR = 1'b0;
        chk("cmd_err_timing", int'(CMD_ERR), int'(xe));
        chk("wren_timing", int'(WrEn), int'(xw));
        chk("rden_timing", int'(RdEn), int'(xr));
    endtask

    // One cycle: optionally present a byte (always dropped: a read is in flight).
    task automatic step(input bit drv, input logic [7:0] b);
        bit xe, xw, xr;
        @(negedge CLK);
        RdData_Valid = 1'b0;
        RX_ERR = 1'b0;
        RX_D_VLD = drv;
        RX_P_DATA = b;
        if (drv) model_byte(b, 1'b0, xe, xw, xr);
    endtask

    function automatic bit rj(input int mode);
        return (mode == 1) && ($urandom % 3 == 0);
    endfunction

    // mode: 0 no extra bytes, 1 random extra bytes, 2 byte 11 in RD_WAIT and 22 in TX_WAIT
    task automatic serve_read(input int d, input int w, input int h, input bit carry, input int mode);
        logic [3:0] a;
        a = Address;
        for (int i = 1; i <= d; i++) begin
            if (mode == 2) step(i == 1, 8'h11);
            else step(rj(mode), 8'($urandom));
            if (i == d) begin
                RdData_Valid = 1'b1;
                RdData = rd_table[a];
                if (carry) TX_BUSY = 1'b1;
            end
        end
        step(rj(mode), 8'($urandom));
        chk("tx_vld_rise", int'(TX_D_VLD), 1);
        if (carry) begin
            step(rj(mode), 8'($urandom)); chk("tx_vld_carry1", int'(TX_D_VLD), 1);
            step(rj(mode), 8'($urandom)); chk("tx_vld_carry2", int'(TX_D_VLD), 1);
            TX_BUSY = 1'b0;
            step(rj(mode), 8'($urandom)); chk("tx_vld_carry_low", int'(TX_D_VLD), 1);
            TX_BUSY = 1'b1;
            step(rj(mode), 8'($urandom)); chk("tx_vld_drop_after_rise", int'(TX_D_VLD), 0);
        end else begin
            for (int i = 0; i < w; i++) begin
                step(rj(mode), 8'($urandom));
                chk("tx_vld_hold", int'(TX_D_VLD), 1);
            end
            TX_BUSY = 1'b1;
            step(rj(mode), 8'($urandom));
            chk("tx_vld_drop", int'(TX_D_VLD), 0);
        end
        for (int i = 0; i < h; i++) begin
            if (mode == 2) step(i == 0, 8'h22);
            else step(rj(mode), 8'($urandom));
            chk("tx_vld_wait", int'(TX_D_VLD), 0);
        end
        TX_BUSY = 1'b0;
        step(1'b0, 8'h00);
        inflight = 0;
    endtask

    task automatic cmd(input logic [7:0] b, input bit e);
        send_byte(b, e);
        if (inflight) serve_read($urandom_range(1, 3), $urandom_range(0, 3),
                                 $urandom_range(0, 3), ($urandom % 4) == 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rd_table[i] = 8'($urandom);
        rd_table[4'hA] = 8'h7E;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("rst_tx_vld", int'(TX_D_VLD), 0);
        chk("rst_wren", int'(WrEn), 0);
        chk("rst_rden", int'(RdEn), 0);
        chk("rst_cmd_err", int'(CMD_ERR), 0);
        chk("rst_addr", int'(Address), 0);
        chk("rst_wrdata", int'(WrData), 0);
        chk("rst_txdata", int'(TX_P_DATA), 0);

        // plain write
        send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h3C, 0);
        // plain read, data two cycles after RdEn
        send_byte(8'hBB, 0); send_byte(8'h0A, 0);
        serve_read(2, 1, 1, 0, 0);
        // bad opcode, error byte, recovery write
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0); send_byte(8'h05, 1);
        send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        chk("addr_hold", int'(Address), 1);
        chk("wrdata_hold", int'(WrData), 2);
        // overlap bytes during RD_WAIT and TX_WAIT
        send_byte(8'hBB, 0); send_byte(8'h0A, 0);
        serve_read(2, 1, 2, 0, 2);
        // reset in WR_DATA
        send_byte(8'hAA, 0); send_byte(8'h03, 0);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        cbuf.delete();
        chk("mid_rst_tx_vld", int'(TX_D_VLD), 0);
        chk("mid_rst_wren", int'(WrEn), 0);
        chk("mid_rst_addr", int'(Address), 0);
        chk("mid_rst_wrdata", int'(WrData), 0);
        chk("mid_rst_cmd_err", int'(CMD_ERR), 0);
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h44, 0);
        // busy carry-over into TX_REQ
        send_byte(8'hBB, 0); send_byte(8'h07, 0);
        serve_read(1, 0, 1, 1, 0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom % 10;
            b = (r < 3) ? 8'hAA : (r < 6) ? 8'hBB : 8'($urandom);
            cmd(b, ($urandom % 12) == 0);
        end

        repeat (4) @(negedge CLK);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_reads", exp_rd.size(), 0);
        chk("pending_tx", exp_tx.size(), 0);
        chk("pending_cmd_err", exp_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-002 SHALL have parameter WR_CMD, default 8'hAA, write-command opcode.
REQ-003 SHALL have parameter RD_CMD, default 8'hBB, read-command opcode.
REQ-004 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port RX_P_DATA  input  8  received byte from UART RX; valid only with RX_D_VLD.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle strobe, new RX byte.
REQ-008 SHALL have port RX_ERR  input  1  parity or framing error for the current RX byte; qualified by RX_D_VLD.
REQ-009 SHALL have port TX_BUSY  input  1  UART TX busy.
REQ-010 SHALL have port TX_P_DATA  output  8  byte to transmit.
REQ-011 SHALL have port TX_D_VLD  output  1  transmit request.
REQ-012 SHALL have port WrEn  output  1  register-file write strobe.
REQ-013 SHALL have port RdEn  output  1  register-file read strobe.
REQ-014 SHALL have port Address  output  ADDR_WIDTH  register-file address.
REQ-015 SHALL have port WrData  output  8  register-file write data.
REQ-016 SHALL have port RdData  input  8  register-file read data.
REQ-017 SHALL have port RdData_Valid  input  1  one-cycle strobe, RdData valid.
REQ-018 SHALL have port CMD_ERR  output  1  one-cycle pulse, dropped or invalid byte.

Function
REQ-019 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ, TX_WAIT; all outputs registered.
REQ-020 IDLE: RX byte == WR_CMD -> WR_ADDR; == RD_CMD -> RD_ADDR; any other value -> stay IDLE, CMD_ERR pulse next cycle.
REQ-021 WR_ADDR: RX byte -> latch RX_P_DATA[ADDR_WIDTH-1:0] into Address (upper bits ignored), go WR_DATA.
REQ-022 WR_DATA: RX byte -> latch into WrData; WrEn = 1 for exactly one cycle, the cycle after RX_D_VLD; go IDLE.
REQ-023 RD_ADDR: RX byte -> latch Address; RdEn = 1 for exactly one cycle, the cycle after RX_D_VLD; go RD_WAIT.
REQ-024 RD_WAIT: on RdData_Valid latch RdData into TX_P_DATA, go TX_REQ; RdData_Valid in any other state ignored.
REQ-025 TX_REQ: TX_D_VLD held 1 and TX_P_DATA stable until TX_BUSY sampled 1; then TX_D_VLD = 0, go TX_WAIT.
REQ-026 TX_REQ entered with TX_BUSY already 1 (previous frame): TX_D_VLD stays 1; wait for a fresh 0->1 transition of TX_BUSY before advancing.
REQ-027 TX_WAIT: TX_BUSY sampled 0 -> IDLE.
REQ-028 RX_D_VLD with RX_ERR = 1 in IDLE, WR_ADDR, WR_DATA or RD_ADDR: byte discarded, no WrEn/RdEn, CMD_ERR pulse, go IDLE.
REQ-029 RX_D_VLD in RD_WAIT, TX_REQ or TX_WAIT: byte discarded, CMD_ERR pulse, state unchanged; one-command-at-a-time rule.
REQ-030 RX_D_VLD and RdData_Valid in the same RD_WAIT cycle: read data taken per REQ-024, RX byte dropped per REQ-029.
REQ-031 Address and WrData SHALL hold their last latched values between commands.
REQ-032 WrEn and RdEn SHALL never both be 1 in the same cycle.
REQ-033 CMD_ERR SHALL be 1 for exactly one cycle per dropped byte, asserted the cycle after RX_D_VLD.
REQ-034 Write command latency: WrEn is asserted the cycle after the third byte's RX_D_VLD; read response: TX_D_VLD rises the cycle after RdData_Valid.

Reset
REQ-035 RST = 1 at a rising edge SHALL force IDLE, TX_D_VLD = 0, WrEn = 0, RdEn = 0, CMD_ERR = 0, Address = 0, WrData = 0, TX_P_DATA = 0, regardless of state.
REQ-036 RST mid-command SHALL abandon the command with no WrEn, RdEn or TX_D_VLD issued afterwards; the next byte is decoded as a new opcode.

Verification
REQ-037 Write: RX bytes AA, 05, 3C -> one WrEn pulse with Address = 5, WrData = 3C, the cycle after the 3C strobe; CMD_ERR stays 0.
REQ-038 Read: RX BB, 0A; RdData = 7E with RdData_Valid 2 cycles after RdEn -> RdEn pulse with Address = A; TX_D_VLD = 1, TX_P_DATA = 7E until TX_BUSY = 1; IDLE after TX_BUSY falls.
REQ-039 Bad opcode and error byte: RX 55 -> CMD_ERR pulse, IDLE. RX AA, then 05 with RX_ERR = 1 -> CMD_ERR pulse, no WrEn; a following AA 01 02 writes 02 to address 1.
REQ-040 Overlap: RX 11 during RD_WAIT and 22 during TX_WAIT -> two CMD_ERR pulses; read response byte unchanged and sent once.
REQ-041 Reset: RST asserted in WR_DATA after AA 03 -> all outputs 0; a following 03 gives a CMD_ERR pulse, and AA 03 44 then writes 44 to address 3.
REQ-042 Busy carry-over: TX_BUSY = 1 on TX_REQ entry, falls after 3 cycles, rises 1 cycle later -> TX_D_VLD held through that interval; it deasserts only after the new rise.
